// File: rtl/byte_en_sp_ram_pkg.sv
// Shared types and constants for the byte-enabled single-port RAM.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package byte_en_sp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/byte_en_sp_ram_core.sv
// Bare byte-enabled storage array with a registered read port and no reset.
// Latency: read data appears one clock after the address; read-first on collisions.
// Backpressure: none; every write strobe is committed at the next clock edge.
module sp_ram_core #(
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int WORD_ADDR_BIT_WIDTH = 6
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [WORD_ADDR_BIT_WIDTH-1:0] i_word_addr,
  input  logic [WORD_BIT_WIDTH/8-1:0]   i_byte_en,
  input  logic [WORD_BIT_WIDTH-1:0]     i_wr_data,
  output logic [WORD_BIT_WIDTH-1:0]     o_rd_data
);

  localparam int NUM_BYTES = WORD_BIT_WIDTH / 8;
  localparam int DEPTH     = 1 << WORD_ADDR_BIT_WIDTH;

  logic [WORD_BIT_WIDTH-1:0] mem [DEPTH];

  // Byte-masked write plus registered read; the read sees the pre-write word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (i_byte_en[b]) begin
          mem[i_word_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
        end
      end
    end
    o_rd_data <= mem[i_word_addr];
  end

endmodule

// File: rtl/byte_en_sp_ram.sv
// Byte-enabled single-port RAM with post-reset zero-fill and dropped-write counter.
// Latency: read data 1 clock after address (2 with OUTPUT_REG_IS_USED); writes visible next cycle.
// Backpressure: none; upstream writes during the zero-fill are discarded and counted.
module byte_en_sp_ram
  import byte_en_sp_ram_pkg::*;
#(
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int WORD_ADDR_BIT_WIDTH = 6,
  parameter bit OUTPUT_REG_IS_USED  = 1'b0,
  parameter bit INIT_ZERO_ON_RESET  = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_async_rst,
  input  logic                           i_we,
  input  logic [WORD_ADDR_BIT_WIDTH-1:0] i_word_addr,
  input  logic [WORD_BIT_WIDTH/8-1:0]    i_byte_en,
  input  logic [WORD_BIT_WIDTH-1:0]      i_wr_data,
  output logic [WORD_BIT_WIDTH-1:0]      o_rd_data,
  output logic                           o_init_busy,
  output logic [7:0]                     o_drop_cnt
);

  if ((WORD_BIT_WIDTH < 8) || ((WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0)) begin : g_bad_word_width
    $error("byte_en_sp_ram: WORD_BIT_WIDTH must be a power of 2 and >= 8");
  end
  if ((WORD_ADDR_BIT_WIDTH < 1) || (WORD_ADDR_BIT_WIDTH > 20)) begin : g_bad_addr_width
    $error("byte_en_sp_ram: WORD_ADDR_BIT_WIDTH must be in 1..20");
  end

  state_t                           state_q;
  state_t                           state_d;
  logic [WORD_ADDR_BIT_WIDTH-1:0]   init_cnt_q;
  logic [7:0]                       drop_cnt_q;
  logic                             rd_gate_q;

  logic                             core_we;
  logic [WORD_ADDR_BIT_WIDTH-1:0]   core_addr;
  logic [WORD_BIT_WIDTH/8-1:0]      core_be;
  logic [WORD_BIT_WIDTH-1:0]        core_wr_data;
  logic [WORD_BIT_WIDTH-1:0]        core_rd_data;
  logic [WORD_BIT_WIDTH-1:0]        rd_gated;

  // State register: start in the fill only when zero-fill is enabled.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state_q <= INIT_ZERO_ON_RESET ? ST_INIT : ST_READY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave the fill once the last word has been written.
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_INIT) && (init_cnt_q == {WORD_ADDR_BIT_WIDTH{1'b1}})) begin
      state_d = ST_READY;
    end
  end

  // Outputs: busy flag and write-port mux (fill sequencer owns the port while busy).
  always_comb begin
    o_init_busy  = (state_q == ST_INIT);
    core_we      = i_we;
    core_addr    = i_word_addr;
    core_be      = i_byte_en;
    core_wr_data = i_wr_data;
    if (state_q == ST_INIT) begin
      core_we      = 1'b1;
      core_addr    = init_cnt_q;
      core_be      = '1;
      core_wr_data = '0;
    end
  end

  // Fill address counter, advances once per fill cycle.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  // Saturating count of upstream writes discarded during the fill.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      drop_cnt_q <= '0;
    end else if ((state_q == ST_INIT) && i_we && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;

  // Read gate: array data is only trusted for reads launched in ST_READY.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      rd_gate_q <= 1'b0;
    end else begin
      rd_gate_q <= (state_q == ST_READY);
    end
  end

  assign rd_gated = rd_gate_q ? core_rd_data : '0;

  sp_ram_core #(
    .WORD_BIT_WIDTH      (WORD_BIT_WIDTH),
    .WORD_ADDR_BIT_WIDTH (WORD_ADDR_BIT_WIDTH)
  ) u_core (
    .i_clk       (i_clk),
    .i_we        (core_we),
    .i_word_addr (core_addr),
    .i_byte_en   (core_be),
    .i_wr_data   (core_wr_data),
    .o_rd_data   (core_rd_data)
  );

  if (OUTPUT_REG_IS_USED) begin : g_out_reg
    logic [WORD_BIT_WIDTH-1:0] rd_out_q;

    // Optional output stage adding one cycle of read latency.
    always_ff @(posedge i_clk or posedge i_async_rst) begin
      if (i_async_rst) begin
        rd_out_q <= '0;
      end else begin
        rd_out_q <= rd_gated;
      end
    end

    assign o_rd_data = rd_out_q;
  end else begin : g_no_out_reg
    assign o_rd_data = rd_gated;
  end

endmodule

// File: tb/tb_byte_en_sp_ram.sv
// Scoreboard bench for byte_en_sp_ram: three instances cover latency 1/2, no-fill and drop saturation.
// Expected responses are queued with a due cycle; a negedge monitor compares them.
// Stimulus is directed, expected values hand-computed.
module tb_byte_en_sp_ram;

  localparam int K_RD   = 0;
  localparam int K_BUSY = 1;
  localparam int K_DROP = 2;

  typedef struct {
    int          due;
    int          dut;
    int          kind;
    logic [31:0] exp;
    int          tag;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  // dut0: fill on, latency 1, 64 words
  logic        we0 = 1'b0;
  logic [5:0]  addr0 = '0;
  logic [3:0]  be0 = '0;
  logic [31:0] wd0 = '0;
  logic [31:0] rd0;
  logic        busy0;
  logic [7:0]  drop0;
  // dut1: no fill, latency 2, 64 words
  logic        we1 = 1'b0;
  logic [5:0]  addr1 = '0;
  logic [3:0]  be1 = '0;
  logic [31:0] wd1 = '0;
  logic [31:0] rd1;
  logic        busy1;
  logic [7:0]  drop1;
  // dut2: fill on, 512 words, used for drop-count saturation
  logic        we2 = 1'b0;
  logic [31:0] rd2;
  logic        busy2;
  logic [7:0]  drop2;

  chk_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   next_tag = 0;

  byte_en_sp_ram #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6), .OUTPUT_REG_IS_USED(1'b0), .INIT_ZERO_ON_RESET(1'b1)) dut0 (
    .i_clk(clk), .i_async_rst(rst), .i_we(we0), .i_word_addr(addr0), .i_byte_en(be0),
    .i_wr_data(wd0), .o_rd_data(rd0), .o_init_busy(busy0), .o_drop_cnt(drop0));

  byte_en_sp_ram #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6), .OUTPUT_REG_IS_USED(1'b1), .INIT_ZERO_ON_RESET(1'b0)) dut1 (
    .i_clk(clk), .i_async_rst(rst), .i_we(we1), .i_word_addr(addr1), .i_byte_en(be1),
    .i_wr_data(wd1), .o_rd_data(rd1), .o_init_busy(busy1), .o_drop_cnt(drop1));

  byte_en_sp_ram #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(9), .OUTPUT_REG_IS_USED(1'b0), .INIT_ZERO_ON_RESET(1'b1)) dut2 (
    .i_clk(clk), .i_async_rst(rst), .i_we(we2), .i_word_addr({3'b000, addr0}), .i_byte_en(be0),
    .i_wr_data(wd0), .o_rd_data(rd2), .o_init_busy(busy2), .o_drop_cnt(drop2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    if (k == K_RD)   return "rd_data";
    if (k == K_BUSY) return "init_busy";
    return "drop_cnt";
  endfunction

  function automatic logic [31:0] actual(input int d, input int k);
    logic [31:0] v;
    v = '0;
    case (d)
      0: v = (k == K_RD) ? rd0 : (k == K_BUSY) ? {31'd0, busy0} : {24'd0, drop0};
      1: v = (k == K_RD) ? rd1 : (k == K_BUSY) ? {31'd0, busy1} : {24'd0, drop1};
      default: v = (k == K_RD) ? rd2 : (k == K_BUSY) ? {31'd0, busy2} : {24'd0, drop2};
    endcase
    return v;
  endfunction

  task automatic expect_at(input int d, input int due, input int k, input logic [31:0] e);
    chk_t c;
    c.due = due; c.dut = d; c.kind = k; c.exp = e; c.tag = next_tag;
    next_tag++;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic we, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    we0 = we; addr0 = a; wd0 = d; be0 = be;
  endtask

  task automatic drive1(input logic we, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    we1 = we; addr1 = a; wd1 = d; be1 = be;
  endtask

  // Monitor: compare every queued expectation that falls due on this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          logic [31:0] a;
          a = actual(sb[i].dut, sb[i].kind);
          n_total++;
          if (sb[i].due < cyc) begin
            $display("FAIL chk%0d dut%0d %s missed its due cycle %0d (now %0d)",
                     sb[i].tag, sb[i].dut, kname(sb[i].kind), sb[i].due, cyc);
          end else if (a !== sb[i].exp) begin
            $display("FAIL chk%0d dut%0d %s cycle %0d: got %h, want %h",
                     sb[i].tag, sb[i].dut, kname(sb[i].kind), cyc, a, sb[i].exp);
          end else begin
            n_pass++;
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0, r1;

    // Reset values
    tick(); tick();
    expect_at(0, cyc, K_RD, 32'h0);
    expect_at(0, cyc, K_DROP, 32'd0);
    expect_at(0, cyc, K_BUSY, 32'd1);
    expect_at(1, cyc, K_BUSY, 32'd0);
    expect_at(1, cyc, K_RD, 32'h0);
    tick();

    // Release reset: fill of 64 words, 3 dropped writes on dut0, 300 on dut2
    rst = 1'b0;
    c0 = cyc;
    expect_at(0, c0, K_DROP, 32'd0);
    expect_at(0, c0 + 2, K_RD, 32'h0);
    expect_at(0, c0 + 3, K_DROP, 32'd3);
    expect_at(0, c0 + 63, K_BUSY, 32'd1);
    expect_at(0, c0 + 64, K_BUSY, 32'd0);
    expect_at(2, c0 + 254, K_DROP, 32'd254);
    expect_at(2, c0 + 255, K_DROP, 32'd255);
    expect_at(2, c0 + 300, K_DROP, 32'd255);
    expect_at(2, c0 + 300, K_BUSY, 32'd1);
    for (int i = 0; i <= 301; i++) begin
      we2 = (i < 300);
      case (i)
        0: drive0(1'b1, 6'd0, 32'hFFFF_FFFF, 4'hF);
        1: drive0(1'b1, 6'd31, 32'hFFFF_FFFF, 4'hF);
        2: drive0(1'b1, 6'd63, 32'hFFFF_FFFF, 4'hF);
        default: drive0(1'b0, 6'd0, 32'h0, 4'h0);
      endcase
      tick();
    end

    // Filled words (including the dropped targets) read zero
    drive0(1'b0, 6'd0, 32'h0, 4'h0);  expect_at(0, cyc + 1, K_RD, 32'h0); tick();
    drive0(1'b0, 6'd31, 32'h0, 4'h0); expect_at(0, cyc + 1, K_RD, 32'h0); tick();
    drive0(1'b0, 6'd63, 32'h0, 4'h0); expect_at(0, cyc + 1, K_RD, 32'h0); tick();

    // Byte enables on word 5
    drive0(1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF); expect_at(0, cyc + 1, K_RD, 32'h0); tick();
    drive0(1'b1, 6'd5, 32'h1122_3344, 4'b0101); expect_at(0, cyc + 1, K_RD, 32'hDEAD_BEEF); tick();
    drive0(1'b0, 6'd5, 32'h0, 4'h0); expect_at(0, cyc + 1, K_RD, 32'hDE22_BE44); tick();

    // Read-first collision on word 9
    drive0(1'b1, 6'd9, 32'hA5A5_A5A5, 4'hF); tick();
    drive0(1'b1, 6'd9, 32'h0, 4'hF); expect_at(0, cyc + 1, K_RD, 32'hA5A5_A5A5); tick();
    drive0(1'b0, 6'd9, 32'h0, 4'h0); expect_at(0, cyc + 1, K_RD, 32'h0); tick();
    tick();

    // Reset mid-fill: restart fill, drop two writes, then abort at fill cycle 20
    rst = 1'b1; tick(); rst = 1'b0;
    r0 = cyc;
    expect_at(0, r0 + 2, K_DROP, 32'd2);
    drive0(1'b1, 6'd5, 32'hFFFF_FFFF, 4'hF); tick(); tick();
    drive0(1'b0, 6'd0, 32'h0, 4'h0);
    while (cyc < r0 + 20) tick();
    rst = 1'b1;
    expect_at(0, cyc, K_DROP, 32'd0);
    expect_at(0, cyc, K_RD, 32'h0);
    expect_at(0, cyc, K_BUSY, 32'd1);
    tick();
    rst = 1'b0;
    r1 = cyc;
    expect_at(0, r1 + 63, K_BUSY, 32'd1);
    expect_at(0, r1 + 64, K_BUSY, 32'd0);

    // No-fill instance: immediate write/readback of word 63, latency 2
    expect_at(1, r1, K_BUSY, 32'd0);
    expect_at(1, r1 + 1, K_RD, 32'h0);
    drive1(1'b1, 6'd63, 32'hCAFE_F00D, 4'hF); tick();
    drive1(1'b0, 6'd63, 32'h0, 4'h0); expect_at(1, cyc + 2, K_RD, 32'hCAFE_F00D); tick();
    drive1(1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF); tick();
    drive1(1'b1, 6'd5, 32'h1122_3344, 4'b0101); expect_at(1, cyc + 2, K_RD, 32'hDEAD_BEEF); tick();
    drive1(1'b0, 6'd5, 32'h0, 4'h0); expect_at(1, cyc + 2, K_RD, 32'hDE22_BE44); tick();
    tick(); tick();

    // After the repeated fill, previously written words read zero again
    while (cyc < r1 + 65) tick();
    drive0(1'b0, 6'd63, 32'h0, 4'h0); expect_at(0, cyc + 1, K_RD, 32'h0); tick();
    drive0(1'b0, 6'd5, 32'h0, 4'h0);  expect_at(0, cyc + 1, K_RD, 32'h0); tick();
    drive0(1'b0, 6'd9, 32'h0, 4'h0);  expect_at(0, cyc + 1, K_RD, 32'h0); tick();

    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    foreach (sb[i]) begin
      n_total++;
      $display("FAIL chk%0d dut%0d %s never compared (due %0d)", sb[i].tag, sb[i].dut, kname(sb[i].kind), sb[i].due);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
